// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - splits 32-bit instruction words into big-endian byte writes
module instr_mem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [31:0]       word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic [ADDR_W-2:0] words_loaded,
  output logic              full
);

  // Memory holds 2^(ADDR_W-2) instructions of 4 bytes each.
  localparam int              MAX_WORDS_INT = 1 << (ADDR_W - 2);
  localparam logic [ADDR_W-2:0] MAX_WORDS   = MAX_WORDS_INT[ADDR_W-2:0];

  // State names the byte currently presented on the write port.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    B0   = 3'd1,
    B1   = 3'd2,
    B2   = 3'd3,
    B3   = 3'd4
  } state_t;

  state_t            state_q;
  logic [23:0]       word_q;     // top byte goes out at accept, only the lower three are kept
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-2:0] cnt_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [7:0]        wr_data_q;
  logic              accept;

  // Flow control: a new word may only enter when no bytes of the previous one remain
  // to be issued after this edge, and never once the memory is full.
  assign full         = (cnt_q == MAX_WORDS);
  assign word_ready   = !reset && !clear && !full && (state_q == IDLE || state_q == B3);
  assign accept       = word_valid && word_ready;

  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign words_loaded = cnt_q;

  // Byte sequencer: accept issues the MSB, then three more bytes follow on consecutive cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      word_q    <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else if (clear) begin
      // Abandon any partially written word; bytes already written stay in memory.
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      wr_en_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, B3: begin
          if (accept) begin
            word_q    <= word_in[23:0];
            state_q   <= B0;
            wr_en_q   <= 1'b1;
            wr_addr_q <= ptr_q;
            wr_data_q <= word_in[31:24];
            ptr_q     <= ptr_q + 1'b1;
            cnt_q     <= cnt_q + 1'b1;
          end else begin
            state_q <= IDLE;
            wr_en_q <= 1'b0;
          end
        end
        B0: begin
          state_q   <= B1;
          wr_en_q   <= 1'b1;
          wr_addr_q <= ptr_q;
          wr_data_q <= word_q[23:16];
          ptr_q     <= ptr_q + 1'b1;
        end
        B1: begin
          state_q   <= B2;
          wr_en_q   <= 1'b1;
          wr_addr_q <= ptr_q;
          wr_data_q <= word_q[15:8];
          ptr_q     <= ptr_q + 1'b1;
        end
        B2: begin
          state_q   <= B3;
          wr_en_q   <= 1'b1;
          wr_addr_q <= ptr_q;
          wr_data_q <= word_q[7:0];
          ptr_q     <= ptr_q + 1'b1;
        end
        default: begin
          state_q <= IDLE;
          wr_en_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb/tb_instr_mem_loader.sv - scoreboard bench for instr_mem_loader
module tb_instr_mem_loader;

  localparam int ADDR_W = 8;
  localparam int NWORDS = 64;

  logic              clk = 1'b0;
  logic              reset;
  logic              clear;
  logic [31:0]       word_in;
  logic              word_valid;
  logic              word_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic [ADDR_W-2:0] words_loaded;
  logic              full;

  instr_mem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .clear        (clear),
    .word_in      (word_in),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .words_loaded (words_loaded),
    .full         (full)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  logic [15:0] exp_q[$];      // {addr, data} for every byte write the model predicts
  logic [31:0] acc_words[$];  // words accepted since last clear/reset, in address order
  logic [7:0]  tbmem [0:255];
  int          m_cnt = 0;
  int          m_busy = 0;
  int          acc_count = 0;
  int          cycle = 0;
  int          last_acc_cycle = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a word may enter when fewer than 64 are loaded and the previous
  // word has at most one byte left; each accepted word yields four MSB-first writes.
  initial begin
    bit          m_ready;
    bit          acc_s;
    bit          clr_s;
    logic [31:0] w_s;
    forever begin
      @(negedge clk);
      m_ready = !reset && !clear && (m_cnt < NWORDS) && (m_busy == 0);
      chk("word_ready", word_ready, m_ready);
      chk("words_loaded", words_loaded, m_cnt);
      chk("full", full, m_cnt == NWORDS);
      acc_s = word_valid && m_ready;
      clr_s = clear && !reset;
      w_s   = word_in;
      @(posedge clk);
      cycle++;
      if (reset) begin
      end else if (clr_s) begin
        m_cnt  = 0;
        m_busy = 0;
        exp_q.delete();
        acc_words.delete();
      end else begin
        if (m_busy > 0) m_busy--;
        if (acc_s) begin
          for (int i = 0; i < 4; i++)
            exp_q.push_back({8'(m_cnt * 4 + i), w_s[31 - 8 * i -: 8]});
          acc_words.push_back(w_s);
          m_cnt++;
          m_busy = 3;
          acc_count++;
          last_acc_cycle = cycle;
        end
      end
    end
  end

  // Monitor: every cycle the write port must carry exactly the next predicted byte, or nothing.
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk);
      chk("wr_en", wr_en, exp_q.size() != 0);
      if (wr_en && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wr_addr", wr_addr, e[15:8]);
        chk("wr_data", wr_data, e[7:0]);
      end else if (exp_q.size() != 0) begin
        void'(exp_q.pop_front());
      end
      if (wr_en) tbmem[wr_addr] = wr_data;
    end
  end

  task automatic send_word(input logic [31:0] w, input int gap, input int limit, output bit ok);
    int n;
    word_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    word_in    = w;
    word_valid = 1'b1;
    n  = acc_count;
    ok = 1'b0;
    for (int c = 0; c < limit; c++) begin
      @(posedge clk);
      #1;
      if (acc_count != n) begin
        ok = 1'b1;
        break;
      end
    end
    word_valid = 1'b0;
    word_in    = $urandom;
  endtask

  task automatic drain();
    for (int c = 0; c < 12 && exp_q.size() != 0; c++) begin
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  task automatic readback(input string tag);
    logic [31:0] got;
    for (int i = 0; i < acc_words.size(); i++) begin
      got = {tbmem[4 * i], tbmem[4 * i + 1], tbmem[4 * i + 2], tbmem[4 * i + 3]};
      chk(tag, got, acc_words[i]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bit ok;
    int c1;
    for (int i = 0; i < 256; i++) tbmem[i] = 8'h00;
    reset      = 1'b1;
    clear      = 1'b0;
    word_valid = 1'b0;
    word_in    = 32'h0;
    #1;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_words_loaded", words_loaded, 0);
    chk("rst_full", full, 0);
    chk("rst_word_ready", word_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Single word
    send_word(32'h12345678, 1, 20, ok);
    chk("single_accept", ok, 1);
    drain();
    chk("single_count", words_loaded, 1);
    chk("single_readback", {tbmem[0], tbmem[1], tbmem[2], tbmem[3]}, 32'h12345678);

    // Back-to-back words with continuous valid
    do_clear();
    send_word(32'hA0000001, 0, 20, ok);
    chk("b2b_accept0", ok, 1);
    c1 = last_acc_cycle;
    send_word(32'hB0000002, 0, 20, ok);
    chk("b2b_accept1", ok, 1);
    chk("b2b_spacing", last_acc_cycle - c1, 4);
    drain();
    chk("b2b_word1", {tbmem[4], tbmem[5], tbmem[6], tbmem[7]}, 32'hB0000002);
    readback("b2b_readback");

    // Fill to capacity with random words and random gaps, then try one more
    do_clear();
    for (int k = 0; k < NWORDS; k++) begin
      send_word($urandom, $urandom_range(0, 3), 20, ok);
      chk("fill_accept", ok, 1);
    end
    drain();
    chk("fill_count", words_loaded, NWORDS);
    chk("fill_full", full, 1);
    chk("fill_ready", word_ready, 0);
    send_word(32'hDEADBEEF, 0, 20, ok);
    chk("overflow_blocked", ok, 0);
    chk("fill_last_byte", tbmem[255], acc_words[NWORDS - 1][7:0]);
    readback("fill_readback");

    // clear in B1 of the word at address 8
    do_clear();
    chk("clear_released_full", full, 0);
    send_word($urandom, 0, 20, ok);
    send_word($urandom, 0, 20, ok);
    send_word(32'hCAFEF00D, 0, 20, ok);
    chk("clr_accept", ok, 1);
    @(posedge clk);
    #1;
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    chk("clr_wr_en", wr_en, 0);
    chk("clr_count", words_loaded, 0);
    send_word(32'h0BADC0DE, 2, 20, ok);
    chk("clr_resume_accept", ok, 1);
    drain();
    readback("clr_resume_readback");

    // Asynchronous reset pulse in the middle of B2
    do_clear();
    send_word(32'h13579BDF, 0, 20, ok);
    chk("rst_mid_accept", ok, 1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("arst_wr_en", wr_en, 0);
    chk("arst_wr_addr", wr_addr, 0);
    chk("arst_wr_data", wr_data, 0);
    chk("arst_words_loaded", words_loaded, 0);
    chk("arst_word_ready", word_ready, 0);
    m_cnt  = 0;
    m_busy = 0;
    exp_q.delete();
    acc_words.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    send_word(32'h2468ACE0, 1, 20, ok);
    chk("arst_resume_accept", ok, 1);
    drain();
    readback("arst_resume_readback");

    // Random gaps on a short run after a clear
    do_clear();
    for (int k = 0; k < 10; k++) begin
      send_word($urandom, $urandom_range(0, 3), 20, ok);
      chk("gap_accept", ok, 1);
    end
    drain();
    chk("gap_count", words_loaded, 10);
    readback("gap_readback");

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
